// File: rtl/move_link_responder_if.sv
// Move-link bundle: received-byte strobe in; move strobe, reply line, status out.
// The slave modport is the responder's side; master is whoever drives the receiver side.
interface move_link_responder_if;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       move_valid;
  logic [7:0] move_out;
  logic       tx_out;
  logic       busy;
  logic [7:0] drop_count;

  modport master (
    output rx_ready,
    output rx_data,
    input  move_valid,
    input  move_out,
    input  tx_out,
    input  busy,
    input  drop_count
  );

  modport slave (
    input  rx_ready,
    input  rx_data,
    output move_valid,
    output move_out,
    output tx_out,
    output busy,
    output drop_count
  );
endinterface

// File: rtl/move_link_responder.sv
// Range-checks received moves, strobes legal ones out 2 cycles after rx_ready and answers ACK/NAK on an 8N1 line.
// Strobes arriving while not IDLE are dropped and counted (saturating); ACK_ECHO_EN makes the ACK echo the move byte.
module move_link_responder #(
  parameter int unsigned DIVISOR   = 6771,
  parameter int unsigned BOARD_MAX = 8,
  parameter logic [7:0]  NAK_BYTE  = 8'hFF,
  parameter logic [7:0]  ACK_BYTE  = 8'h06
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  move_link_responder_if.slave  link
);

  localparam int TW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [TW-1:0] BIT_LAST = TW'(DIVISOR - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    reply, reply_nxt;
  logic [7:0]    move_q, move_nxt;
  logic          mv_q, mv_nxt;
  logic          tx_q, tx_nxt;
  logic          busy_q, busy_nxt;
  logic [7:0]    drop_q, drop_nxt;
  logic          bit_done;
  logic          legal;
  logic [7:0]    ack_reply;

  assign bit_done = (timer == BIT_LAST);
  assign legal    = (32'(reply[7:4]) <= BOARD_MAX) && (32'(reply[3:0]) <= BOARD_MAX);

`ifdef ACK_ECHO_EN
  assign ack_reply = reply;
`else
  assign ack_reply = ACK_BYTE;
`endif

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    bit_idx_nxt = bit_idx;
    reply_nxt   = reply;
    move_nxt    = move_q;
    mv_nxt      = 1'b0;
    drop_nxt    = drop_q;

    if (link.rx_ready && (state != IDLE) && (drop_q != 8'hFF))
      drop_nxt = drop_q + 8'd1;

    case (state)
      IDLE: begin
        if (link.rx_ready) begin
          reply_nxt = link.rx_data;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        timer_nxt   = '0;
        bit_idx_nxt = 3'd0;
        state_nxt   = START;
        if (legal) begin
          move_nxt  = reply;
          mv_nxt    = 1'b1;
          reply_nxt = ack_reply;
        end else begin
          reply_nxt = NAK_BYTE;
        end
      end
      START: begin
        if (bit_done) begin
          timer_nxt = '0;
          state_nxt = DATA;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          timer_nxt   = '0;
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7)
            state_nxt = STOP;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          timer_nxt = '0;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase

    // Line level is computed from the next state so tx_out stays a plain register.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = reply_nxt[bit_idx_nxt];
      default: tx_nxt = 1'b1;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= 3'd0;
      reply   <= 8'h00;
      move_q  <= 8'h00;
      mv_q    <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      drop_q  <= 8'h00;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      bit_idx <= bit_idx_nxt;
      reply   <= reply_nxt;
      move_q  <= move_nxt;
      mv_q    <= mv_nxt;
      tx_q    <= tx_nxt;
      busy_q  <= busy_nxt;
      drop_q  <= drop_nxt;
    end
  end

  assign link.move_valid = mv_q;
  assign link.move_out   = move_q;
  assign link.tx_out     = tx_q;
  assign link.busy       = busy_q;
  assign link.drop_count = drop_q;

endmodule

// File: tb/tb_move_link_responder.sv
// Randomized scoreboard bench for move_link_responder with DIVISOR=4.
module tb_move_link_responder;
  localparam int D     = 4;
  localparam int FRAME = 10 * D + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  move_link_responder_if link();

  move_link_responder #(
    .DIVISOR   (D),
    .BOARD_MAX (8),
    .NAK_BYTE  (8'hFF),
    .ACK_BYTE  (8'h06)
  ) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .link   (link)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] tx_q[$];
  logic [7:0] mv_q[$];
  int         next_free = 0;
  int         drops_m   = 0;
  logic [7:0] last_move = 8'h00;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit legal_m(input logic [7:0] d);
    return (int'(d[7:4]) <= 8) && (int'(d[3:0]) <= 8);
  endfunction

  function automatic logic [7:0] reply_m(input logic [7:0] d);
    if (!legal_m(d)) return 8'hFF;
`ifdef ACK_ECHO_EN
    return d;
`else
    return 8'h06;
`endif
  endfunction

  // Reference: a strobe sampled at edge e is accepted only if the previous
  // accepted byte's frame (FRAME cycles) has fully finished by then.
  task automatic model_strobe(input int e, input logic [7:0] d);
    if (e >= next_free) begin
      next_free = e + FRAME;
      tx_q.push_back(reply_m(d));
      if (legal_m(d)) begin
        mv_q.push_back(d);
        last_move = d;
      end
    end else begin
      drops_m = (drops_m < 255) ? drops_m + 1 : 255;
    end
  endtask

  task automatic drive_cycle(input bit v, input logic [7:0] d);
    link.rx_ready = v;
    link.rx_data  = d;
    if (v) model_strobe(cyc + 1, d);
    @(posedge clk);
    #1;
    link.rx_ready = 1'b0;
    if (v) check("drop_count", int'(link.drop_count), drops_m);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'($urandom));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_tx_out",     int'(link.tx_out),     1);
    check("rst_busy",       int'(link.busy),       0);
    check("rst_move_valid", int'(link.move_valid), 0);
    check("rst_move_out",   int'(link.move_out),   0);
    check("rst_drop_count", int'(link.drop_count), 0);
    tx_q.delete();
    mv_q.delete();
    next_free = 0;
    drops_m   = 0;
    last_move = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Serial line monitor: decodes each 8N1 frame by sampling near mid-bit.
  bit         mact = 1'b0;
  int         mcnt = 0;
  logic [7:0] mbyte = 8'h00;
  always @(negedge clk) begin
    if (!rst_n) begin
      mact = 1'b0;
    end else if (!mact) begin
      if (link.tx_out == 1'b0) begin
        mact = 1'b1;
        mcnt = 0;
      end
    end else begin
      mcnt++;
      if (mcnt == 1) check("start_bit", int'(link.tx_out), 0);
      if ((mcnt % D == 1) && (mcnt / D >= 1) && (mcnt / D <= 8))
        mbyte[mcnt / D - 1] = link.tx_out;
      if (mcnt == 9 * D + 1) begin
        check("stop_bit", int'(link.tx_out), 1);
        if (tx_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL tx_frame: got unexpected byte 0x%0h, expected no frame", mbyte);
        end else begin
          check("tx_byte", int'(mbyte), int'(tx_q.pop_front()));
        end
      end
      if (mcnt == 10 * D - 1) mact = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && link.move_valid) begin
      if (mv_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL move_valid: got pulse with move_out 0x%0h, expected none", link.move_out);
      end else begin
        check("move_out_strobe", int'(link.move_out), int'(mv_q.pop_front()));
      end
    end
  end

  initial begin
    logic [7:0] d;
    int wait_cnt;
    link.rx_ready = 1'b0;
    link.rx_data  = 8'h00;
    #2;
    do_reset();
    idle(3);

    // Legal move with cycle-exact timing checks.
    drive_cycle(1'b1, 8'h35);
    @(negedge clk);
    check("busy_cycle1", int'(link.busy), 1);
    @(posedge clk);
    @(negedge clk);
    check("tx_start_cycle2", int'(link.tx_out), 0);
    check("move_out_cycle2", int'(link.move_out), 8'h35);
    repeat (39) @(posedge clk);
    @(negedge clk);
    check("busy_cycle41", int'(link.busy), 1);
    @(posedge clk);
    @(negedge clk);
    check("busy_cycle42", int'(link.busy), 0);
    @(posedge clk);
    #1;
    idle(2);

    // Illegal move keeps move_out.
    drive_cycle(1'b1, 8'h92);
    idle(FRAME + 3);
    check("move_out_after_nak", int'(link.move_out), 8'h35);

    // Strobe at cycle 10 of a frame is dropped.
    drive_cycle(1'b1, 8'h47);
    idle(9);
    drive_cycle(1'b1, 8'h11);
    check("drop_one", int'(link.drop_count), 1);
    idle(FRAME + 3);
    check("move_out_not_dropped", int'(link.move_out), 8'h47);

    // Continuous strobes saturate the drop counter.
    for (int i = 0; i < 300; i++) drive_cycle(1'b1, 8'($urandom));
    check("drop_saturated", int'(link.drop_count), 255);
    idle(FRAME + 3);

    // Reset during data bit 3, then a clean frame.
    drive_cycle(1'b1, 8'h26);
    idle(18);
    do_reset();
    drive_cycle(1'b1, 8'h58);
    idle(FRAME + 3);
    check("move_out_after_abort", int'(link.move_out), 8'h58);

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      idle($urandom_range(0, 50));
      if ($urandom_range(0, 1) == 1)
        d = {4'($urandom_range(0, 8)), 4'($urandom_range(0, 8))};
      else
        d = 8'($urandom);
      drive_cycle(1'b1, d);
    end

    wait_cnt = 0;
    while ((tx_q.size() != 0 || link.busy) && wait_cnt < 200) begin
      idle(1);
      wait_cnt++;
    end
    idle(2);
    check("drain_timeout", (wait_cnt < 200) ? 1 : 0, 1);
    check("tx_queue_empty", tx_q.size(), 0);
    check("mv_queue_empty", mv_q.size(), 0);
    check("final_move_out", int'(link.move_out), int'(last_move));
    check("final_drop_count", int'(link.drop_count), drops_m);
    check("final_tx_idle", int'(link.tx_out), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
